multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multicycle MIPS control FSM; drives the ALU's 4-bit ALUctl and all datapath enables/selects.
//  Sequences fetch/decode/execute/memory/writeback per instruction from IR opcode/funct.
//  Consumes ALU Zero for beq; waits on a mem_ready handshake at every memory access.
// PARAMETERS
//  MEM_TIMEOUT  16  max wait cycles for mem_ready per access; 0 = wait forever
// PORTS
//  clk          in   1  system clock, all state updates on rising edge
//  rst_n        in   1  asynchronous active-low reset
//  opcode       in   6  IR[31:26], stable after IR load
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU Zero flag
//  mem_ready    in   1  memory has completed current read/write this cycle
//  alu_ctl      out  4  ALU op: 0 AND,1 OR,2 ADD,6 SUB,7 SLT,11 LUI,12 NOR
//  alu_src_a    out  1  0=PC, 1=reg A
//  alu_src_b    out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  pc_source    out  2  00=ALU result, 01=ALUOut reg, 10=jump target
//  pc_write     out  1  PC load enable (already qualified by zero for beq)
//  i_or_d       out  1  0=instr addr (PC), 1=data addr (ALUOut)
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  ir_write     out  1  IR load enable
//  reg_dst      out  1  0=rt, 1=rd
//  mem_to_reg   out  1  0=ALUOut, 1=MDR
//  reg_write    out  1  register file write enable
//  instr_done   out  1  1-cycle pulse on last cycle of each instruction
//  illegal_op   out  1  1-cycle pulse in DECODE for unsupported opcode/funct
//  bus_error    out  1  1-cycle pulse when a memory wait hits MEM_TIMEOUT
//  state        out  4  current state (debug)
// BEHAVIOUR
//  - States (enc): FETCH0 DECODE1 MEM_ADDR2 MEM_RD3 MEM_WB4 MEM_WR5 R_EXEC6 R_WB7 BRANCH8 JUMP9 I_EXEC10 I_WB11.
//  - Reset: state=FETCH, wait counter=0; outputs are Moore decode of FETCH with pc_write=ir_write=0
//    until mem_ready: mem_read=1, alu_ctl=2, alu_src_a=0, alu_src_b=01, pc_source=00, all other 1-bit outputs 0.
//  - FETCH: mem_read=1,i_or_d=0, PC+4 on ALU; stays until mem_ready; on mem_ready: ir_write=1, pc_write=1 -> DECODE.
//  - DECODE: alu_ctl=2, src_a=0, src_b=11 (branch target to ALUOut). Next by opcode:
//    0x23 lw/0x2B sw ->MEM_ADDR; 0x00 R ->R_EXEC; 0x04 beq ->BRANCH; 0x02 j ->JUMP;
//    0x08 addi/0x0C andi/0x0D ori/0x0A slti/0x0F lui ->I_EXEC; else illegal_op=1 ->FETCH.
//    R-type funct not in {0x20 add,0x22 sub,0x24 and,0x25 or,0x27 nor,0x2A slt}: illegal_op=1 ->FETCH.
//  - MEM_ADDR: alu_ctl=2,src_a=1,src_b=10 -> MEM_RD (lw) / MEM_WR (sw).
//  - MEM_RD: mem_read=1,i_or_d=1; hold until mem_ready -> MEM_WB. MEM_WR: mem_write=1,i_or_d=1;
//    hold until mem_ready; then instr_done=1 -> FETCH.
//  - MEM_WB: reg_write=1,mem_to_reg=1,reg_dst=0, instr_done=1 -> FETCH.
//  - R_EXEC: src_a=1,src_b=00, alu_ctl from funct (add2 sub6 and0 or1 nor12 slt7) -> R_WB.
//  - R_WB: reg_write=1,reg_dst=1,mem_to_reg=0, instr_done=1 -> FETCH.
//  - I_EXEC: src_a=1,src_b=10; alu_ctl addi2 andi0 ori1 slti7 lui11 -> I_WB (reg_dst=0, else as R_WB).
//    Note andi/ori use sign-extended imm (no zero-ext path in datapath); decided, not a bug.
//  - BRANCH: alu_ctl=6,src_a=1,src_b=00, pc_source=01, pc_write=zero (same cycle), instr_done=1 -> FETCH.
//  - JUMP: pc_source=10, pc_write=1, instr_done=1 -> FETCH.
//  - Wait counter: clears on entry to any memory state; increments each cycle mem_ready=0 there;
//    if MEM_TIMEOUT!=0 and count reaches MEM_TIMEOUT-1 with mem_ready=0: bus_error=1, -> FETCH,
//    no ir/pc/reg write that cycle. mem_ready and timeout same cycle: mem_ready wins.
//  - mem_read/mem_write never both 1; reg_write and pc_write never both 1.
//  - rst_n low mid-instruction: immediate return to FETCH, counter cleared, no pending writes completed.
// STRUCTURE
//  - Shared include mips_defs.vh: ALU ctl codes, opcode/funct constants, state encodings, ALUSrcB/PCSource encodings.
//  - Sub-module alu_ctl_decode: combinational (state-class, opcode, funct) -> alu_ctl, reused by R_EXEC/I_EXEC.
//  - Top: state register + wait counter (sequential), Moore output decode (combinational).
// TESTING
//  - add (op 0x00,funct 0x20), mem_ready=1 always -> FETCH,DECODE,R_EXEC(alu_ctl=2),R_WB(reg_write,reg_dst=1); 4 cycles, one instr_done.
//  - lw (0x23) with mem_ready low 3 cycles in MEM_RD -> state holds 3 cycles, MEM_WB reg_write=1 mem_to_reg=1; 8 cycles total.
//  - beq (0x04) zero=1 -> BRANCH pc_write=1,pc_source=01,alu_ctl=6; zero=0 -> pc_write=0; both 3 cycles.
//  - lui (0x0F) -> I_EXEC alu_ctl=11,src_b=10; opcode 0x3F -> illegal_op pulse in DECODE, back to FETCH.
//  - MEM_TIMEOUT=16, mem_ready held 0 in FETCH -> bus_error on 16th cycle, ir_write/pc_write never asserted.
//  - rst_n low during MEM_WR -> mem_write drops asynchronously, state=0 while reset held, clean fetch after release.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control slice.
// Contents: state encodings, ALU control codes, opcode/funct constants,
// ALUSrcB/PCSource encodings, ALU-control class enum, legality helper.
package multicycle_control_pkg;

  // state   | meaning
  // FETCH    | read instruction at PC, PC+4 on ALU
  // DECODE   | register read, branch target into ALUOut
  // MEM_ADDR | effective address for lw/sw
  // MEM_RD   | data read, wait on mem_ready
  // MEM_WB   | MDR to rt
  // MEM_WR   | data write, wait on mem_ready
  // R_EXEC   | R-type ALU op
  // R_WB     | ALUOut to rd
  // BRANCH   | beq compare and conditional PC load
  // JUMP     | PC <- jump target
  // I_EXEC   | immediate ALU op
  // I_WB     | ALUOut to rt
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXEC   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_I_EXEC   = 4'd10;
  localparam logic [3:0] S_I_WB     = 4'd11;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_LUI = 4'd11;
  localparam logic [3:0] ALU_NOR = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Which rule picks the ALU op in the current state.
  typedef enum logic [1:0] {
    ACLS_ADD,
    ACLS_SUB,
    ACLS_FUNCT,
    ACLS_OPCODE
  } alu_cls_e;

  function automatic logic op_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT};
      OP_LW, OP_SW, OP_BEQ, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and the datapath/memory.
// master: controller (consumes IR fields, zero, mem_ready; drives controls).
// slave : datapath side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [3:0] alu_ctl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       instr_done;
  logic       illegal_op;
  logic       bus_error;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_ctl, alu_src_a, alu_src_b, pc_source, pc_write, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           instr_done, illegal_op, bus_error, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_ctl, alu_src_a, alu_src_b, pc_source, pc_write, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           instr_done, illegal_op, bus_error, state
  );
endinterface

// File: rtl/multicycle_control_alu_ctl_decode.sv
// Combinational ALU control decode.
// cls_i     : which rule applies (fixed ADD, fixed SUB, from funct, from opcode)
// opcode_i  : IR[31:26]
// funct_i   : IR[5:0]
// alu_ctl_o : 4-bit ALU operation
module alu_ctl_decode
  import multicycle_control_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctl_o
);

  always_comb begin
    alu_ctl_o = ALU_ADD;
    case (cls_i)
      ACLS_SUB: alu_ctl_o = ALU_SUB;
      ACLS_FUNCT: begin
        case (funct_i)
          FN_SUB:  alu_ctl_o = ALU_SUB;
          FN_AND:  alu_ctl_o = ALU_AND;
          FN_OR:   alu_ctl_o = ALU_OR;
          FN_NOR:  alu_ctl_o = ALU_NOR;
          FN_SLT:  alu_ctl_o = ALU_SLT;
          default: alu_ctl_o = ALU_ADD;
        endcase
      end
      ACLS_OPCODE: begin
        case (opcode_i)
          OP_ANDI: alu_ctl_o = ALU_AND;
          OP_ORI:  alu_ctl_o = ALU_OR;
          OP_SLTI: alu_ctl_o = ALU_SLT;
          OP_LUI:  alu_ctl_o = ALU_LUI;
          default: alu_ctl_o = ALU_ADD;
        endcase
      end
      default: alu_ctl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback and drives every datapath enable/select plus the ALU op.
// clk   : system clock
// rst_n : asynchronous active-low reset (back to FETCH, wait counter 0)
// ctl   : control bus, master side (see multicycle_control_if)
// MEM_TIMEOUT: max wait cycles for mem_ready per access, 0 = no limit
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master ctl
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             mem_state;
  logic             timeout;
  logic             legal;
  alu_cls_e         alu_cls;
  logic [3:0]       alu_ctl_w;

  assign mem_state = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  assign legal     = op_legal(ctl.opcode, ctl.funct);
  // mem_ready wins over an expiring counter in the same cycle.
  assign timeout   = (MEM_TIMEOUT != 0) && mem_state && !ctl.mem_ready &&
                     (wait_q == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (ctl.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (!legal) state_d = S_FETCH;
        else begin
          case (ctl.opcode)
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_RTYPE:     state_d = S_R_EXEC;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
            default:      state_d = S_I_EXEC;
          endcase
        end
      end
      S_MEM_ADDR: state_d = (ctl.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (ctl.mem_ready)  state_d = S_MEM_WB;
        else if (timeout)   state_d = S_FETCH;
      end
      S_MEM_WR:   if (ctl.mem_ready || timeout) state_d = S_FETCH;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Counter only runs while stalled in a memory state; any exit, re-entry
  // after a timeout, or non-memory state leaves it at zero.
  assign wait_d = (mem_state && !ctl.mem_ready && !timeout) ? wait_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  alu_ctl_decode u_alu_ctl_decode (
    .cls_i     (alu_cls),
    .opcode_i  (ctl.opcode),
    .funct_i   (ctl.funct),
    .alu_ctl_o (alu_ctl_w)
  );

  assign ctl.alu_ctl = alu_ctl_w;
  assign ctl.state   = state_q;

  always_comb begin
    alu_cls        = ACLS_ADD;
    ctl.alu_src_a  = 1'b0;
    ctl.alu_src_b  = SRCB_REG;
    ctl.pc_source  = PCSRC_ALU;
    ctl.pc_write   = 1'b0;
    ctl.i_or_d     = 1'b0;
    ctl.mem_read   = 1'b0;
    ctl.mem_write  = 1'b0;
    ctl.ir_write   = 1'b0;
    ctl.reg_dst    = 1'b0;
    ctl.mem_to_reg = 1'b0;
    ctl.reg_write  = 1'b0;
    ctl.instr_done = 1'b0;
    ctl.illegal_op = 1'b0;
    ctl.bus_error  = timeout;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.ir_write  = ctl.mem_ready;
        ctl.pc_write  = ctl.mem_ready;
      end
      S_DECODE: begin
        ctl.alu_src_b  = SRCB_IMM_SH2;
        ctl.illegal_op = !legal;
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        ctl.mem_write  = 1'b1;
        ctl.i_or_d     = 1'b1;
        ctl.instr_done = ctl.mem_ready;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_R_EXEC: begin
        alu_cls       = ACLS_FUNCT;
        ctl.alu_src_a = 1'b1;
      end
      S_I_EXEC: begin
        alu_cls       = ACLS_OPCODE;
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
      end
      S_R_WB, S_I_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = (state_q == S_R_WB);
        ctl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_cls        = ACLS_SUB;
        ctl.alu_src_a  = 1'b1;
        ctl.pc_source  = PCSRC_ALUOUT;
        ctl.pc_write   = ctl.zero;
        ctl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_source  = PCSRC_JUMP;
        ctl.pc_write   = 1'b1;
        ctl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each planned instruction expands
// into per-cycle stimulus and expected observations; a driver replays the
// stimulus while a monitor pops and compares expectations every cycle.
module tb_multicycle_control;
  localparam int T = 16;
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3,
                         MEM_WB = 4'd4, MEM_WR = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7,
                         BRANCH = 4'd8, JUMP = 4'd9, I_EXEC = 4'd10, I_WB = 4'd11;

  typedef struct packed {
    logic [3:0] st; logic [3:0] alu; logic sa; logic [1:0] sb; logic [1:0] ps;
    logic pcw, iord, mrd, mwr, irw, rdst, m2r, rw, done, ill, berr;
  } obs_t;
  typedef struct packed { obs_t val; obs_t care; } exp_t;
  typedef struct packed { logic [5:0] op; logic [5:0] fn; logic z; logic rdy; } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t  exp_q[$];
  stim_t stim_q[$];
  logic [5:0] legal_ops [10] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0F};
  logic [5:0] legal_fns [6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

  always #5 clk = ~clk;

  multicycle_control_if bus();
  multicycle_control #(.MEM_TIMEOUT(T)) dut (.clk(clk), .rst_n(rst_n), .ctl(bus));

  function automatic obs_t observe();
    obs_t o;
    o.st = bus.state; o.alu = bus.alu_ctl; o.sa = bus.alu_src_a; o.sb = bus.alu_src_b;
    o.ps = bus.pc_source; o.pcw = bus.pc_write; o.iord = bus.i_or_d; o.mrd = bus.mem_read;
    o.mwr = bus.mem_write; o.irw = bus.ir_write; o.rdst = bus.reg_dst; o.m2r = bus.mem_to_reg;
    o.rw = bus.reg_write; o.done = bus.instr_done; o.ill = bus.illegal_op; o.berr = bus.bus_error;
    return o;
  endfunction

  task automatic check(input string name, input exp_t e);
    logic [23:0] a, v, c;
    a = observe(); v = e.val; c = e.care;
    total++;
    if (((a ^ v) & c) != 24'd0) begin
      bad++;
      $display("FAIL %s: got %h want %h (mask %h)", name, a, v, c);
    end
  endtask

  task automatic check_inv(input string name);
    total++;
    if (bus.mem_read && bus.mem_write) begin
      bad++; $display("FAIL %s rd_wr_excl: got both mem_read and mem_write, want not both", name);
    end
    total++;
    if (bus.reg_write && bus.pc_write) begin
      bad++; $display("FAIL %s rw_pcw_excl: got both reg_write and pc_write, want not both", name);
    end
  endtask

  // Reference tables: ALU op per funct / opcode, -1 = not supported.
  function automatic int r_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return 2;  6'h22: return 6;  6'h24: return 0;
      6'h25: return 1;  6'h27: return 12; 6'h2A: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic int i_alu(input logic [5:0] op);
    case (op)
      6'h08: return 2; 6'h0C: return 0; 6'h0D: return 1; 6'h0A: return 7; 6'h0F: return 11;
      default: return -1;
    endcase
  endfunction

  function automatic exp_t base(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.val.st = st; e.care.st = '1;
    e.care.pcw = 1'b1; e.care.mrd = 1'b1; e.care.mwr = 1'b1; e.care.irw = 1'b1;
    e.care.rw = 1'b1; e.care.done = 1'b1; e.care.ill = 1'b1; e.care.berr = 1'b1;
    return e;
  endfunction

  function automatic exp_t alu_sel(input exp_t ein, input int alu, input logic sa, input logic [1:0] sb);
    exp_t e;
    e = ein;
    e.val.alu = 4'(alu); e.care.alu = '1;
    e.val.sa = sa; e.care.sa = 1'b1;
    e.val.sb = sb; e.care.sb = '1;
    return e;
  endfunction

  function automatic exp_t wb(input logic [3:0] st, input logic rdst);
    exp_t e;
    e = base(st);
    e.val.rw = 1'b1; e.val.done = 1'b1;
    e.val.rdst = rdst; e.care.rdst = 1'b1; e.care.m2r = 1'b1;
    return e;
  endfunction

  task automatic push(input exp_t e, input stim_t s);
    exp_q.push_back(e);
    stim_q.push_back(s);
  endtask

  // w stall cycles with mem_ready low; the T-th stalled cycle is the bus error.
  task automatic stall(input exp_t ein, input stim_t sin, input int w, output bit ok);
    exp_t e; stim_t s;
    e = ein; s = sin; s.rdy = 1'b0; ok = 1'b1;
    for (int k = 0; k < w; k++) begin
      if (k == T - 1) begin
        e.val.berr = 1'b1; push(e, s); ok = 1'b0; return;
      end
      push(e, s);
    end
  endtask

  task automatic plan(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input int fw, input int mw);
    stim_t s; exp_t e; bit ok; int ra, ia; bit legal;
    s.op = op; s.fn = fn; s.z = z; s.rdy = 1'b1;
    ra = r_alu(fn); ia = i_alu(op);
    e = alu_sel(base(FETCH), 2, 1'b0, 2'b01);
    e.val.mrd = 1'b1; e.care.iord = 1'b1; e.care.ps = '1;
    stall(e, s, fw, ok);
    if (!ok) return;
    e.val.pcw = 1'b1; e.val.irw = 1'b1;
    push(e, s);
    legal = (op == 6'h23) || (op == 6'h2B) || (op == 6'h00 && ra >= 0) ||
            (op == 6'h04) || (op == 6'h02) || (ia >= 0);
    e = alu_sel(base(DECODE), 2, 1'b0, 2'b11);
    e.val.ill = !legal;
    push(e, s);
    if (!legal) return;
    case (op)
      6'h23, 6'h2B: begin
        push(alu_sel(base(MEM_ADDR), 2, 1'b1, 2'b10), s);
        e = base(op == 6'h23 ? MEM_RD : MEM_WR);
        e.val.iord = 1'b1; e.care.iord = 1'b1;
        if (op == 6'h23) e.val.mrd = 1'b1; else e.val.mwr = 1'b1;
        stall(e, s, mw, ok);
        if (!ok) return;
        if (op == 6'h2B) e.val.done = 1'b1;
        push(e, s);
        if (op == 6'h23) begin
          e = wb(MEM_WB, 1'b0); e.val.m2r = 1'b1;
          push(e, s);
        end
      end
      6'h00: begin
        push(alu_sel(base(R_EXEC), ra, 1'b1, 2'b00), s);
        push(wb(R_WB, 1'b1), s);
      end
      6'h04: begin
        e = alu_sel(base(BRANCH), 6, 1'b1, 2'b00);
        e.val.ps = 2'b01; e.care.ps = '1; e.val.pcw = z; e.val.done = 1'b1;
        push(e, s);
      end
      6'h02: begin
        e = base(JUMP);
        e.val.ps = 2'b10; e.care.ps = '1; e.val.pcw = 1'b1; e.val.done = 1'b1;
        push(e, s);
      end
      default: begin
        push(alu_sel(base(I_EXEC), ia, 1'b1, 2'b10), s);
        push(wb(I_WB, 1'b0), s);
      end
    endcase
  endtask

  task automatic run_queues();
    fork
      begin
        stim_t s;
        while (stim_q.size() != 0) begin
          s = stim_q.pop_front();
          bus.opcode = s.op; bus.funct = s.fn; bus.zero = s.z; bus.mem_ready = s.rdy;
          @(posedge clk); #1;
        end
      end
      begin
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
          @(negedge clk);
          check($sformatf("cyc%0d", n), exp_q.pop_front());
          check_inv($sformatf("cyc%0d", n));
          n++;
        end
      end
    join
    bus.mem_ready = 1'b0;
  endtask

  function automatic exp_t fetch_idle();
    exp_t e;
    e = alu_sel(base(FETCH), 2, 1'b0, 2'b01);
    e.val.mrd = 1'b1;
    e.care = '1;
    return e;
  endfunction

  initial begin
    exp_t e;
    int fw, mw;
    logic [5:0] op, fn;
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    #12;
    check("reset_outputs", fetch_idle());
    @(posedge clk); #1;
    rst_n = 1'b1;

    plan(6'h00, 6'h20, 1'b0, 0, 0);   // add
    plan(6'h23, 6'h00, 1'b0, 0, 3);   // lw, 3 stall cycles in MEM_RD
    plan(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
    plan(6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
    plan(6'h0F, 6'h00, 1'b0, 0, 0);   // lui
    plan(6'h3F, 6'h00, 1'b0, 0, 0);   // illegal opcode
    plan(6'h00, 6'h21, 1'b0, 0, 0);   // illegal funct
    plan(6'h00, 6'h20, 1'b0, 16, 0);  // fetch timeout
    plan(6'h2B, 6'h00, 1'b0, 1, 15);  // sw, ready on last cycle before timeout
    plan(6'h23, 6'h00, 1'b0, 0, 16);  // lw data-read timeout
    plan(6'h02, 6'h00, 1'b0, 15, 0);  // j, fetch ready just in time
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 5)];
      fw = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
      plan(op, fn, 1'($urandom), fw, mw);
    end
    run_queues();

    // Reset asserted in the middle of a store.
    bus.opcode = 6'h2B; bus.funct = 6'h00; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    e = base(MEM_WR); e.val.mwr = 1'b1;
    check("in_mem_wr", e);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", fetch_idle());
    @(posedge clk); #1;
    check("reset_held", fetch_idle());
    rst_n = 1'b1;
    plan(6'h00, 6'h22, 1'b0, 0, 0);   // clean sub after release
    run_queues();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
